traffic_light_monitor: RTL and testbench

//  Receiving end of the traffic-light lamp interface (red/yellow/green, one-hot).

---
 rtl/traffic_light_pkg.sv | 26 ++
 rtl/traffic_phase_timer.sv | 46 ++++
 rtl/traffic_light_monitor.sv | 162 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types, default phase windows and the legal phase-order rule for the
// traffic-light controller and its monitor.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_UNKNOWN = 2'd0,
    PH_RED     = 2'd1,
    PH_GREEN   = 2'd2,
    PH_YELLOW  = 2'd3
  } phase_t;

  localparam int unsigned CntWDef      = 16;
  localparam int unsigned RedMinDef    = 10;
  localparam int unsigned RedMaxDef    = 12;
  localparam int unsigned GreenMinDef  = 8;
  localparam int unsigned GreenMaxDef  = 10;
  localparam int unsigned YellowMinDef = 2;
  localparam int unsigned YellowMaxDef = 4;

  function automatic logic legal_next(phase_t cur, phase_t nxt);
    return ((cur == PH_RED)    && (nxt == PH_GREEN))  ||
           ((cur == PH_GREEN)  && (nxt == PH_YELLOW)) ||
           ((cur == PH_YELLOW) && (nxt == PH_RED));
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Saturating phase-duration counter with MIN/MAX window compare against the
// window of the phase currently being timed.
module traffic_phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             incr,
  input  logic [CNT_W-1:0] win_min,
  input  logic [CNT_W-1:0] win_max,
  output logic [CNT_W-1:0] count,
  output logic             under_min,
  output logic             overrun_next
);

  localparam logic [CNT_W-1:0] CntSat = '1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start) begin
      count_d = CNT_W'(1);
    end else if (incr && (count_q != CntSat)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count        = count_q;
  assign under_min    = (count_q < win_min);
  // The next increment lands exactly on MAX+1; a saturated counter never re-fires.
  assign overrun_next = (count_q == win_max) && (count_q != CntSat);

endmodule

// File: rtl/traffic_light_monitor.sv
// In-system checker for the traffic-light lamp interface: decodes the phase,
// times each phase and flags illegal encodings, bad ordering and bad durations.
module traffic_light_monitor import traffic_light_pkg::*; #(
  parameter int unsigned CNT_W      = CntWDef,
  parameter int unsigned RED_MIN    = RedMinDef,
  parameter int unsigned RED_MAX    = RedMaxDef,
  parameter int unsigned GREEN_MIN  = GreenMinDef,
  parameter int unsigned GREEN_MAX  = GreenMaxDef,
  parameter int unsigned YELLOW_MIN = YellowMinDef,
  parameter int unsigned YELLOW_MAX = YellowMaxDef
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [1:0]       phase,
  output logic             phase_done,
  output logic [CNT_W-1:0] phase_len,
  output logic             err_illegal,
  output logic             err_sequence,
  output logic             err_timing,
  output logic             err_sticky,
  output logic [7:0]       err_count
);

  logic             red_q, yellow_q, green_q, lamp_vld_q;
  phase_t           phase_q, phase_d;
  logic             first_q, first_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ill_q, ill_d, seq_q, seq_d, tim_q, tim_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       count_q, count_d;

  phase_t           lamp_phase;
  logic             lamp_legal;
  logic [CNT_W-1:0] win_min, win_max, t_count;
  logic             t_clear, t_start, t_incr, t_under, t_overrun;
  logic             any_err;

  always_comb begin
    lamp_phase = PH_UNKNOWN;
    lamp_legal = 1'b1;
    case ({red_q, green_q, yellow_q})
      3'b100:  lamp_phase = PH_RED;
      3'b010:  lamp_phase = PH_GREEN;
      3'b001:  lamp_phase = PH_YELLOW;
      default: lamp_legal = 1'b0;
    endcase
  end

  always_comb begin
    win_min = '0;
    win_max = '0;
    case (phase_q)
      PH_RED:    begin win_min = CNT_W'(RED_MIN);    win_max = CNT_W'(RED_MAX);    end
      PH_GREEN:  begin win_min = CNT_W'(GREEN_MIN);  win_max = CNT_W'(GREEN_MAX);  end
      PH_YELLOW: begin win_min = CNT_W'(YELLOW_MIN); win_max = CNT_W'(YELLOW_MAX); end
      default:   ;
    endcase
  end

  traffic_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (t_clear),
    .start       (t_start),
    .incr        (t_incr),
    .win_min     (win_min),
    .win_max     (win_max),
    .count       (t_count),
    .under_min   (t_under),
    .overrun_next(t_overrun)
  );

  always_comb begin
    phase_d = phase_q;
    first_d = first_q;
    done_d  = 1'b0;
    len_d   = len_q;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    tim_d   = 1'b0;
    t_clear = 1'b0;
    t_start = 1'b0;
    t_incr  = 1'b0;
    // The lamp register holds no real sample for the first cycle after reset.
    if (lamp_vld_q) begin
      if (!lamp_legal) begin
        ill_d   = 1'b1;
        phase_d = PH_UNKNOWN;
        t_clear = 1'b1;
      end else if (phase_q == PH_UNKNOWN) begin
        phase_d = lamp_phase;
        first_d = 1'b1;
        t_start = 1'b1;
      end else if (lamp_phase == phase_q) begin
        t_incr = 1'b1;
        tim_d  = !first_q && t_overrun;
      end else begin
        done_d  = 1'b1;
        len_d   = t_count;
        phase_d = lamp_phase;
        first_d = 1'b0;
        t_start = 1'b1;
        if (!legal_next(phase_q, lamp_phase)) begin
          seq_d = 1'b1;
        end else begin
          tim_d = !first_q && t_under;
        end
      end
    end
    any_err  = ill_d | seq_d | tim_d;
    sticky_d = sticky_q | any_err;
    count_d  = (any_err && (count_q != 8'hff)) ? count_q + 8'd1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_q      <= 1'b0;
      yellow_q   <= 1'b0;
      green_q    <= 1'b0;
      lamp_vld_q <= 1'b0;
      phase_q    <= PH_UNKNOWN;
      first_q    <= 1'b1;
      done_q     <= 1'b0;
      len_q      <= '0;
      ill_q      <= 1'b0;
      seq_q      <= 1'b0;
      tim_q      <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      red_q      <= red;
      yellow_q   <= yellow;
      green_q    <= green;
      lamp_vld_q <= 1'b1;
      phase_q    <= phase_d;
      first_q    <= first_d;
      done_q     <= done_d;
      len_q      <= len_d;
      ill_q      <= ill_d;
      seq_q      <= seq_d;
      tim_q      <= tim_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign phase        = phase_q;
  assign phase_done   = done_q;
  assign phase_len    = len_q;
  assign err_illegal  = ill_q;
  assign err_sequence = seq_q;
  assign err_timing   = tim_q;
  assign err_sticky   = sticky_q;
  assign err_count    = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed laps plus randomized phase streams, checked every cycle against a
// run-length reference model of the lamp protocol.
module tb_traffic_light_monitor;

  localparam int CNT_W = 16;
  localparam logic [2:0] LR = 3'b100;  // {red, yellow, green}
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic             clk = 1'b0;
  logic             reset, red, yellow, green;
  logic [1:0]       phase;
  logic             phase_done, err_illegal, err_sequence, err_timing, err_sticky;
  logic [CNT_W-1:0] phase_len;
  logic [7:0]       err_count;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .phase       (phase),
    .phase_done  (phase_done),
    .phase_len   (phase_len),
    .err_illegal (err_illegal),
    .err_sequence(err_sequence),
    .err_timing  (err_timing),
    .err_sticky  (err_sticky),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Phase codes: 0 unknown, 1 red, 2 green, 3 yellow.
  int         min_of [4] = '{0, 10, 8, 2};
  int         max_of [4] = '{0, 12, 10, 4};
  int         succ   [4] = '{0, 2, 3, 1};
  logic [2:0] lamp_of[4] = '{3'b000, LR, LG, LY};
  logic [2:0] bad    [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  int         m_phase, m_len, m_plen, m_count;
  bit         m_partial, m_sticky, m_done, m_ill, m_seq, m_tim;
  bit         pv;
  logic [2:0] plamp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lamp_to_phase(input logic [2:0] l);
    if ($countones(l) != 1) return 0;
    if (l[2]) return 1;
    if (l[0]) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_plen = 0; m_count = 0;
    m_partial = 1; m_sticky = 0;
    m_done = 0; m_ill = 0; m_seq = 0; m_tim = 0;
  endtask

  task automatic model_step(input bit valid, input logic [2:0] l);
    int p;
    m_done = 0; m_ill = 0; m_seq = 0; m_tim = 0;
    if (valid) begin
      p = lamp_to_phase(l);
      if (p == 0) begin
        m_ill = 1; m_phase = 0; m_len = 0;
      end else if (m_phase == 0) begin
        m_phase = p; m_len = 1; m_partial = 1;
      end else if (p == m_phase) begin
        if (m_len < 65535) m_len++;
        if (!m_partial && m_len == max_of[p] + 1) m_tim = 1;
      end else begin
        m_done = 1;
        m_plen = m_len;
        if (succ[m_phase] != p) m_seq = 1;
        else if (!m_partial && m_len < min_of[m_phase]) m_tim = 1;
        m_phase = p; m_len = 1; m_partial = 0;
      end
    end
    if (m_ill || m_seq || m_tim) begin
      m_sticky = 1;
      if (m_count < 255) m_count++;
    end
  endtask

  // One clock: drive lamps/reset, step the model after the edge, compare everything.
  task automatic cycle(input logic [2:0] l, input bit rst);
    {red, yellow, green} = l;
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      pv = 0;
    end else begin
      model_step(pv, plamp);
      pv = 1;
      plamp = l;
    end
    check_eq("phase",        32'(phase),        32'(m_phase));
    check_eq("phase_done",   32'(phase_done),   32'(m_done));
    check_eq("phase_len",    32'(phase_len),    32'(m_plen));
    check_eq("err_illegal",  32'(err_illegal),  32'(m_ill));
    check_eq("err_sequence", 32'(err_sequence), 32'(m_seq));
    check_eq("err_timing",   32'(err_timing),   32'(m_tim));
    check_eq("err_sticky",   32'(err_sticky),   32'(m_sticky));
    check_eq("err_count",    32'(err_count),    32'(m_count));
    @(negedge clk);
  endtask

  task automatic seg(input int p, input int n);
    repeat (n) cycle(lamp_of[p], 1'b0);
  endtask

  initial begin
    int cur, nxt, lo, k;
    reset = 1'b1;
    {red, yellow, green} = 3'b000;
    pv = 0;
    plamp = 3'b000;
    model_reset();
    @(negedge clk);
    cycle(3'b000, 1'b1);
    cycle(3'b000, 1'b1);
    check_eq("reset_phase", 32'(phase), 32'd0);
    check_eq("reset_count", 32'(err_count), 32'd0);

    repeat (3) begin seg(1, 11); seg(2, 9); seg(3, 3); end
    check_eq("laps_err_count", 32'(err_count), 32'd0);

    seg(1, 11); seg(2, 7); seg(3, 3);
    check_eq("short_green_count", 32'(err_count), 32'd1);
    check_eq("short_green_sticky", 32'(err_sticky), 32'd1);

    seg(1, 20); seg(2, 9); seg(3, 3);
    check_eq("long_red_count", 32'(err_count), 32'd2);

    seg(1, 11); seg(2, 9); seg(1, 11);
    check_eq("seq_count", 32'(err_count), 32'd3);
    check_eq("seq_len", 32'(phase_len), 32'd9);
    check_eq("seq_phase", 32'(phase), 32'd1);

    cycle(3'b101, 1'b0);
    seg(1, 11); seg(2, 9); seg(3, 3);
    check_eq("illegal_count", 32'(err_count), 32'd4);

    cur = 3;
    for (int s = 0; s < 80; s++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        repeat ($urandom_range(1, 2)) cycle(bad[$urandom_range(0, 4)], 1'b0);
      end else begin
        nxt = (k == 1) ? int'($urandom_range(1, 3)) : succ[cur];
        lo  = (min_of[nxt] > 3) ? min_of[nxt] - 3 : 1;
        seg(nxt, int'($urandom_range(lo, max_of[nxt] + 3)));
        cur = nxt;
      end
    end

    repeat (300) cycle(3'b111, 1'b0);
    check_eq("sat_count", 32'(err_count), 32'd255);

    seg(1, 11); seg(2, 4);
    cycle(LG, 1'b1);
    check_eq("midrst_sticky", 32'(err_sticky), 32'd0);
    check_eq("midrst_count", 32'(err_count), 32'd0);
    check_eq("midrst_phase", 32'(phase), 32'd0);
    check_eq("midrst_len", 32'(phase_len), 32'd0);
    seg(2, 5); seg(3, 3); seg(1, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
